// File: rtl/spi_ram.sv
// Command-driven byte memory behind the SPI slave: 10-bit words carry a 2-bit opcode
// plus payload, with independent auto-incrementing write and read pointers.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    typedef enum logic {WR_IDLE, WR_ARMED} wr_state_t;
    typedef enum logic {RD_IDLE, RD_ARMED} rd_state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    wr_state_t            wr_state;
    rd_state_t            rd_state;

    logic [1:0] op;
    logic       wr_en;

    assign op    = din[9:8];
    assign wr_en = !rst && rx_valid && (op == OP_WR_DATA) && (wr_state == WR_ARMED);

    // Storage has no reset so contents survive rst; rst still blocks the write.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= din[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            dout     <= 8'h00;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
            if (rx_valid) begin
                case (op)
                    OP_WR_ADDR: begin
                        wr_addr  <= din[ADDR_SIZE-1:0];
                        wr_state <= WR_ARMED;
                    end
                    OP_WR_DATA: begin
                        if (wr_state == WR_ARMED)
                            wr_addr <= wr_addr + ADDR_SIZE'(1);
                        else
                            cmd_err <= 1'b1;
                    end
                    OP_RD_ADDR: begin
                        rd_addr  <= din[ADDR_SIZE-1:0];
                        rd_state <= RD_ARMED;
                    end
                    OP_RD_DATA: begin
                        if (rd_state == RD_ARMED) begin
                            dout     <= mem[rd_addr];
                            tx_valid <= 1'b1;
                            rd_addr  <= rd_addr + ADDR_SIZE'(1);
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Bench for spi_ram: directed vector table, idle-bus check, then random traffic
// against a command-level reference model.
module tb_spi_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(dout), .tx_valid(tx_valid), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: memory image, two pointers, two armed flags, expected outputs.
    logic [7:0] m_mem [256];
    logic [7:0] m_wa, m_ra, m_dout;
    bit         m_warm, m_rarm, m_tx, m_err;

    typedef struct {
        logic       r;
        logic       v;
        logic [9:0] d;
        logic       tx;
        logic [7:0] dout;
        logic       err;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic [9:0] d);
        m_tx  = 0;
        m_err = 0;
        if (r) begin
            m_wa = 0; m_ra = 0; m_dout = 0; m_warm = 0; m_rarm = 0;
        end else if (v) begin
            case (d[9:8])
                2'd0: begin m_wa = d[7:0]; m_warm = 1; end
                2'd1: if (m_warm) begin m_mem[m_wa] = d[7:0]; m_wa = m_wa + 8'd1; end
                      else m_err = 1;
                2'd2: begin m_ra = d[7:0]; m_rarm = 1; end
                default: if (m_rarm) begin m_dout = m_mem[m_ra]; m_tx = 1; m_ra = m_ra + 8'd1; end
                         else m_err = 1;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [9:0] d);
        rst = r; rx_valid = v; din = d;
        @(posedge clk);
        #1;
        model(r, v, d);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".tx_valid"}, {7'd0, tx_valid}, {7'd0, m_tx});
        check({tag, ".cmd_err"},  {7'd0, cmd_err},  {7'd0, m_err});
        check({tag, ".dout"},     dout,             m_dout);
    endtask

    vec_t vecs [$];

    initial begin
        // reset, then read-data while idle
        vecs.push_back('{1, 0, 10'h000, 0, 8'h00, 0});
        vecs.push_back('{0, 1, 10'h300, 0, 8'h00, 1});
        vecs.push_back('{0, 0, 10'h000, 0, 8'h00, 0});
        // basic write two, read two
        vecs.push_back('{0, 1, 10'h010, 0, 8'h00, 0});
        vecs.push_back('{0, 1, 10'h1A5, 0, 8'h00, 0});
        vecs.push_back('{0, 1, 10'h13C, 0, 8'h00, 0});
        vecs.push_back('{0, 1, 10'h210, 0, 8'h00, 0});
        vecs.push_back('{0, 1, 10'h300, 1, 8'hA5, 0});
        vecs.push_back('{0, 1, 10'h300, 1, 8'h3C, 0});
        vecs.push_back('{0, 0, 10'h3FF, 0, 8'h3C, 0});
        // wrap-around 0xFF -> 0x00
        vecs.push_back('{0, 1, 10'h0FF, 0, 8'h3C, 0});
        vecs.push_back('{0, 1, 10'h111, 0, 8'h3C, 0});
        vecs.push_back('{0, 1, 10'h122, 0, 8'h3C, 0});
        vecs.push_back('{0, 1, 10'h2FF, 0, 8'h3C, 0});
        vecs.push_back('{0, 1, 10'h300, 1, 8'h11, 0});
        vecs.push_back('{0, 1, 10'h300, 1, 8'h22, 0});
        // back-to-back write then read of the same address
        vecs.push_back('{0, 1, 10'h040, 0, 8'h22, 0});
        vecs.push_back('{0, 1, 10'h177, 0, 8'h22, 0});
        vecs.push_back('{0, 1, 10'h240, 0, 8'h22, 0});
        vecs.push_back('{0, 1, 10'h300, 1, 8'h77, 0});
        // reset mid-read, both channels disarmed, memory kept
        vecs.push_back('{0, 1, 10'h240, 0, 8'h77, 0});
        vecs.push_back('{1, 1, 10'h300, 0, 8'h00, 0});
        vecs.push_back('{0, 1, 10'h300, 0, 8'h00, 1});
        vecs.push_back('{0, 1, 10'h155, 0, 8'h00, 1});
        vecs.push_back('{0, 1, 10'h240, 0, 8'h00, 0});
        vecs.push_back('{0, 1, 10'h300, 1, 8'h77, 0});
        vecs.push_back('{0, 0, 10'h000, 0, 8'h77, 0});

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d.tx_valid", i), {7'd0, tx_valid}, {7'd0, vecs[i].tx});
            check($sformatf("vec%0d.cmd_err", i),  {7'd0, cmd_err},  {7'd0, vecs[i].err});
            check($sformatf("vec%0d.dout", i),     dout,             vecs[i].dout);
        end

        // bus idle with din toggling: nothing may happen
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 10'($urandom));
            check_model($sformatf("idle%0d", i));
        end
        step(0, 1, 10'h240);
        step(0, 1, 10'h300);
        check_model("idle_readback");

        // fill every location so random reads are fully predictable
        step(0, 1, 10'h000);
        for (int i = 0; i < 256; i++)
            step(0, 1, {2'b01, 8'($urandom)});

        for (int i = 0; i < 3000; i++) begin
            logic r, v;
            r = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 3) != 0);
            step(r, v, 10'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
